// File: rtl/bp_sacc_scratchpad_sum.sv
// Sacc responder: uncached CSR/scratchpad access on the IO CCE port plus a
// multi-cycle sum engine that accumulates scratchpad words into RESULT.
package bp_sacc_scratchpad_sum_pkg;
  localparam int paddr_width_p     = 40;
  localparam int cce_block_width_p = 512;
  localparam int lce_id_width_p    = 4;
  localparam int lce_assoc_p       = 8;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0]      lce_id;
    logic [$clog2(lce_assoc_p)-1:0] way_id;
    logic [2:0]                     state;
  } bp_bedrock_cce_mem_payload_s;

  typedef struct packed {
    bp_bedrock_cce_mem_payload_s payload;
    logic [2:0]                  size;
    logic [paddr_width_p-1:0]    addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_cce_mem_header_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    bp_bedrock_cce_mem_header_s   header;
  } bp_bedrock_cce_mem_msg_s;
endpackage

module bp_sacc_scratchpad_sum
  import bp_sacc_scratchpad_sum_pkg::*;
#(
  parameter int          els_p       = 64,
  parameter logic [19:0] spad_base_p = 20'h10000
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [lce_id_width_p-1:0] lce_id_i,
  input  bp_bedrock_cce_mem_msg_s io_cmd_i,
  input  logic                    io_cmd_v_i,
  output logic                    io_cmd_ready_o,
  output bp_bedrock_cce_mem_msg_s io_resp_o,
  output logic                    io_resp_v_o,
  input  logic                    io_resp_yumi_i
);

  localparam int idx_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = idx_w_lp + 1;

  typedef enum logic [1:0] {e_ready, e_exec, e_resp} state_e;

  // Clamp the requested run length to the scratchpad depth.
  function automatic logic [cnt_w_lp-1:0] sat_len(input logic [63:0] len);
    if (len > 64'(els_p)) return cnt_w_lp'(els_p);
    else                  return len[cnt_w_lp-1:0];
  endfunction

  state_e                  state_r, state_n;
  bp_bedrock_cce_mem_msg_s cmd_r;
  logic [63:0]             rdata_r, rdata_n;
  logic [63:0]             spad_mem [els_p];

  logic                    busy_r;
  logic [idx_w_lp-1:0]     idx_r;
  logic [cnt_w_lp-1:0]     n_r, n_start;
  logic [63:0]             len_r, result_r, count_r;

  logic [19:0]             offset, spad_off;
  logic [63:0]             wdata, spad_rdata;
  logic [idx_w_lp-1:0]     cmd_idx, spad_addr;
  logic                    is_wr, is_rd, spad_hit, stall, exec_fire, start;

  assign offset    = cmd_r.header.addr[19:0];
  assign wdata     = cmd_r.data[63:0];
  assign is_wr     = (cmd_r.header.msg_type == e_bedrock_mem_uc_wr);
  assign is_rd     = (cmd_r.header.msg_type == e_bedrock_mem_uc_rd);
  assign spad_off  = offset - spad_base_p;
  assign spad_hit  = (offset >= spad_base_p) && (spad_off < 20'(8 * els_p))
                     && (offset[2:0] == 3'b000);
  assign cmd_idx   = spad_off[idx_w_lp+2:3];
  assign stall     = spad_hit && (is_wr || is_rd) && busy_r;
  assign exec_fire = (state_r == e_exec) && !stall;
  assign start     = exec_fire && is_wr && (offset == 20'h0) && wdata[0] && !busy_r;
  assign n_start   = sat_len(len_r);

  // Single read port: the engine owns it while busy, the command path otherwise.
  assign spad_addr  = busy_r ? idx_r : cmd_idx;
  assign spad_rdata = spad_mem[spad_addr];

  always_ff @(posedge clk_i) begin
    if (exec_fire && is_wr && spad_hit) spad_mem[cmd_idx] <= wdata;
  end

  always_comb begin
    rdata_n = '0;
    if (is_rd) begin
      if (spad_hit)                rdata_n = spad_rdata;
      else if (offset == 20'h00)   rdata_n = {63'b0, busy_r};
      else if (offset == 20'h08)   rdata_n = len_r;
      else if (offset == 20'h10)   rdata_n = result_r;
      else if (offset == 20'h18)   rdata_n = count_r;
    end
  end

  always_ff @(posedge clk_i) begin
    if (io_cmd_v_i && io_cmd_ready_o) cmd_r   <= io_cmd_i;
    if (exec_fire)                    rdata_r <= rdata_n;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_r   <= 1'b0;
      idx_r    <= '0;
      n_r      <= '0;
      len_r    <= '0;
      result_r <= '0;
      count_r  <= '0;
    end else begin
      if (exec_fire && is_wr && (offset == 20'h08)) len_r <= wdata;
      if (start) begin
        result_r <= '0;
        idx_r    <= '0;
        n_r      <= n_start;
        busy_r   <= (n_start != '0);
        if (n_start == '0) count_r <= count_r + 64'd1;
      end else if (busy_r) begin
        result_r <= result_r + spad_rdata;
        idx_r    <= idx_r + idx_w_lp'(1);
        if ({1'b0, idx_r} == n_r - cnt_w_lp'(1)) begin
          busy_r  <= 1'b0;
          count_r <= count_r + 64'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_ready;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready: if (io_cmd_v_i && io_cmd_ready_o) state_n = e_exec;
      e_exec:  if (!stall)                       state_n = e_resp;
      e_resp:  if (io_resp_yumi_i)               state_n = e_ready;
      default:                                   state_n = e_ready;
    endcase
  end

  always_comb begin
    io_cmd_ready_o = (state_r == e_ready) && !reset_i;
    io_resp_v_o    = (state_r == e_resp)  && !reset_i;
  end

  assign io_resp_o.header = cmd_r.header;
  assign io_resp_o.data   = cce_block_width_p'(rdata_r);

  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(io_resp_yumi_i && !io_resp_v_o));
  end

  logic unused;
  assign unused = ^{lce_id_i, cmd_r.data[cce_block_width_p-1:64], cmd_r.header.size,
                    cmd_r.header.payload, cmd_r.header.addr[paddr_width_p-1:20]};

endmodule

// File: tb/tb_bp_sacc_scratchpad_sum.sv
// Directed bench for bp_sacc_scratchpad_sum: CSR/scratchpad access, sum engine
// runs, stall and hold behaviour, and reset in the middle of a run.
module tb_bp_sacc_scratchpad_sum;
  import bp_sacc_scratchpad_sum_pkg::*;

  localparam logic [19:0] SPAD = 20'h10000;

  logic                      clk_i = 1'b0;
  logic                      reset_i = 1'b1;
  logic [lce_id_width_p-1:0] lce_id_i = '0;
  bp_bedrock_cce_mem_msg_s   io_cmd_i;
  logic                      io_cmd_v_i = 1'b0;
  logic                      io_cmd_ready_o;
  bp_bedrock_cce_mem_msg_s   io_resp_o;
  logic                      io_resp_v_o;
  logic                      io_resp_yumi_i = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int last_lat;

  bp_sacc_scratchpad_sum #(.els_p(64), .spad_base_p(SPAD)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .lce_id_i(lce_id_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bp_bedrock_cce_mem_msg_s mk(input bp_bedrock_mem_type_e mt,
                                                 input logic [19:0] off, input logic [63:0] wd);
    bp_bedrock_cce_mem_msg_s m;
    m = '0;
    m.header.msg_type = mt;
    m.header.addr     = paddr_width_p'(off);
    m.header.size     = 3'b011;
    m.data[63:0]      = wd;
    return m;
  endfunction

  // One full command/response exchange; lat counts edges from handshake to visible resp_v.
  task automatic xact(input bp_bedrock_mem_type_e mt, input logic [19:0] off,
                      input logic [63:0] wd, output logic [63:0] rd, output int lat);
    bp_bedrock_cce_mem_msg_s m;
    int guard;
    m = mk(mt, off, wd);
    @(negedge clk_i);
    io_cmd_i = m;
    io_cmd_v_i = 1'b1;
    guard = 0;
    while (!io_cmd_ready_o && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    chk("cmd_ready", io_cmd_ready_o, 1);
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
    lat = 1;
    while (!io_resp_v_o && lat < 500) begin
      @(negedge clk_i);
      lat++;
    end
    rd = io_resp_o.data[63:0];
    n_cmp++;
    assert (io_resp_v_o === 1'b1 && io_resp_o.header === m.header)
    else begin
      n_err++;
      $error("FAIL resp_hdr: observed v=%b hdr=%h expected v=1 hdr=%h",
             io_resp_v_o, io_resp_o.header, m.header);
    end
    io_resp_yumi_i = io_resp_v_o;
    @(negedge clk_i);
    io_resp_yumi_i = 1'b0;
  endtask

  task automatic wr(input logic [19:0] off, input logic [63:0] wd);
    logic [63:0] d;
    xact(e_bedrock_mem_uc_wr, off, wd, d, last_lat);
    chk("wr_resp_data", d, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [19:0] off, input logic [63:0] exp);
    logic [63:0] d;
    xact(e_bedrock_mem_uc_rd, off, '0, d, last_lat);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [63:0] d, d0;
    logic        stable;
    io_cmd_i = '0;

    repeat (3) @(negedge clk_i);
    chk("rst_ready", io_cmd_ready_o, 0);
    chk("rst_resp_v", io_resp_v_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", io_cmd_ready_o, 1);
    rd_chk("len_rst", 20'h08, 0);
    rd_chk("result_rst", 20'h10, 0);
    rd_chk("count_rst", 20'h18, 0);

    // Basic run of four words
    for (int i = 0; i < 4; i++) wr(SPAD + 20'(8 * i), 64'(i + 1));
    wr(20'h08, 4);
    wr(20'h00, 1);
    rd_chk("busy_poll1", 20'h00, 1);
    chk("csr_lat", last_lat, 2);
    rd_chk("busy_poll2", 20'h00, 0);
    rd_chk("result_4", 20'h10, 10);
    rd_chk("count_1", 20'h18, 1);

    // Carry out of bit 63 is dropped
    wr(SPAD, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(SPAD + 20'h8, 2);
    wr(20'h08, 2);
    wr(20'h00, 1);
    rd_chk("busy_n2", 20'h00, 0);
    rd_chk("result_wrap", 20'h10, 1);
    rd_chk("count_2", 20'h18, 2);
    wr(20'h10, 5);
    rd_chk("result_ro", 20'h10, 1);

    // Zero-length run
    wr(20'h08, 0);
    wr(20'h00, 1);
    rd_chk("busy_n0", 20'h00, 0);
    rd_chk("result_n0", 20'h10, 0);
    rd_chk("count_3", 20'h18, 3);

    // LEN clamped to depth; scratchpad read stalls until the run ends
    for (int i = 0; i < 64; i++) wr(SPAD + 20'(8 * i), 64'(3 * i + 1));
    wr(20'h08, 1000);
    wr(20'h00, 1);
    rd_chk("spad_stall_rd", SPAD + 20'(8 * 5), 16);
    chk("stall_lat_64", last_lat, 63);
    rd_chk("result_64", 20'h10, 6112);
    rd_chk("count_4", 20'h18, 4);

    // CSR reads during busy, ignored second start
    wr(20'h08, 64);
    wr(20'h00, 1);
    rd_chk("busy_during_run", 20'h00, 1);
    chk("busy_rd_lat", last_lat, 2);
    wr(20'h00, 1);
    rd_chk("spad_rd_63", SPAD + 20'(8 * 63), 190);
    chk("no_restart_lat", last_lat, 55);
    rd_chk("count_5", 20'h18, 5);
    rd_chk("result_again", 20'h10, 6112);

    // Response held stable while yumi is low
    @(negedge clk_i);
    io_cmd_i = mk(e_bedrock_mem_uc_rd, 20'h10, '0);
    io_cmd_v_i = 1'b1;
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
    @(negedge clk_i);
    chk("hold_v", io_resp_v_o, 1);
    d0 = io_resp_o.data[63:0];
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (!(io_resp_v_o === 1'b1 && io_resp_o.data[63:0] === d0 && io_cmd_ready_o === 1'b0))
        stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    chk("hold_data", d0, 6112);
    io_resp_yumi_i = 1'b1;
    @(negedge clk_i);
    io_resp_yumi_i = 1'b0;

    // Non-uncached types act as reads of zero and do not write
    xact(e_bedrock_mem_rd, 20'h18, '0, d, last_lat);
    chk("other_type_rd", d, 0);
    xact(e_bedrock_mem_wr, 20'h08, 77, d, last_lat);
    chk("other_type_wr", d, 0);
    rd_chk("len_unchanged", 20'h08, 64);
    wr(20'h20, 64'h1234);
    rd_chk("unmapped_rd", 20'h20, 0);

    // Reset in the middle of a run with a stalled scratchpad read pending
    wr(20'h00, 1);
    @(negedge clk_i);
    io_cmd_i = mk(e_bedrock_mem_uc_rd, SPAD, '0);
    io_cmd_v_i = 1'b1;
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_ready", io_cmd_ready_o, 0);
    chk("midrst_resp_v", io_resp_v_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("after_rst_ready", io_cmd_ready_o, 1);
    chk("after_rst_resp_v", io_resp_v_o, 0);
    rd_chk("after_rst_count", 20'h18, 0);
    rd_chk("after_rst_len", 20'h08, 0);
    rd_chk("after_rst_result", 20'h10, 0);
    rd_chk("after_rst_busy", 20'h00, 0);
    rd_chk("spad_kept", SPAD + 20'(8 * 5), 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
